// File: rtl/aesproject_nios2_mul_seq_if.sv
// Request/response bundle between a multiply requester and the multiply sequencer.
// Latency: none, wires only.
// Backpressure: valid/ready on both directions; the producer holds its payload until ready.
interface aesproject_nios2_mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        req_hi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  // Requester side: issues operands, consumes the result.
  modport master (
    output req_valid, req_src1, req_src2, req_hi, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  // Sequencer side: accepts operands, produces the result.
  modport slave (
    input  req_valid, req_src1, req_src2, req_hi, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/aesproject_nios2_mul_seq.sv
// Sequences a 32x32 unsigned multiply through a three-product 16x16 cell, returning the low or high word.
// Latency: 3 cycles from accept to rsp_valid for the low word, 5 for the high word.
// Backpressure: req_ready only in IDLE; result and rsp_valid held stable in DONE until rsp_ready.
module aesproject_nios2_mul_seq (
  input  logic                              clk,
  input  logic                              reset_n,
  aesproject_nios2_mul_seq_if.slave         bus,
  output logic                              busy,
  output logic [31:0]                       mc_src1,
  output logic [31:0]                       mc_src2,
  output logic                              mc_en,
  input  logic [31:0]                       mc_p1,
  input  logic [31:0]                       mc_p2,
  input  logic [31:0]                       mc_p3
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS1 = 3'd1,
    ST_CAP1  = 3'd2,
    ST_PASS2 = 3'd3,
    ST_CAP2  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        hi_q, hi_d;
  logic [63:0] lo_acc_q, lo_acc_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_valid_q, rsp_valid_d;

  // Partial-product combination terms.
  logic [32:0] mid;
  logic [63:0] lo_sum;
  logic [31:0] hi_word;

  // Combine the pass-1 cross products into the 64-bit low accumulation, and fold in hi*hi for pass 2.
  // Only the upper word of hi*hi << 32 touches the result, so the high word is a 32-bit add.
  always_comb begin
    mid     = {1'b0, mc_p2} + {1'b0, mc_p3};
    lo_sum  = {32'b0, mc_p1} + {15'b0, mid, 16'b0};
    hi_word = lo_acc_q[63:32] + mc_p1;
  end

  // Next-state and datapath update; everything holds unless the current state says otherwise.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_acc_d     = lo_acc_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_src1;
          b_d     = bus.req_src2;
          hi_d    = bus.req_hi;
          state_d = ST_PASS1;
        end
      end
      ST_PASS1: begin
        state_d = ST_CAP1;
      end
      ST_CAP1: begin
        lo_acc_d = lo_sum;
        if (hi_q) begin
          state_d = ST_PASS2;
        end else begin
          rsp_result_d = lo_sum[31:0];
          rsp_valid_d  = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_PASS2: begin
        state_d = ST_CAP2;
      end
      ST_CAP2: begin
        rsp_result_d = hi_word;
        rsp_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      hi_q         <= 1'b0;
      lo_acc_q     <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_acc_q     <= lo_acc_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // Cell drive and handshake outputs, decoded from the current state only.
  // Pass 2 feeds the upper halves so the cell's lo*lo product becomes A_hi*B_hi.
  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    busy           = (state_q != ST_IDLE);
    mc_en          = (state_q == ST_PASS1) || (state_q == ST_PASS2);
    mc_src1        = a_q;
    mc_src2        = b_q;
    if (state_q == ST_PASS2) begin
      mc_src1 = {16'b0, a_q[31:16]};
      mc_src2 = {16'b0, b_q[31:16]};
    end
    bus.rsp_valid  = rsp_valid_q;
    bus.rsp_result = rsp_result_q;
  end

endmodule

// File: tb/tb_aesproject_nios2_mul_seq.sv
// Directed bench for the multiply sequencer, with a latency-level reference model and a registered cell model.
// Latency: low word 3 cycles, high word 5 cycles from accept.
// Backpressure: exercises held rsp_ready, pending requests while busy, and reset mid-operation.
module tb_aesproject_nios2_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        busy;
  logic [31:0] mc_src1, mc_src2;
  logic        mc_en;
  logic [31:0] mc_p1, mc_p2, mc_p3;

  int checks = 0;
  int errors = 0;

  aesproject_nios2_mul_seq_if bus ();

  aesproject_nios2_mul_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .mc_src1 (mc_src1),
    .mc_src2 (mc_src2),
    .mc_en   (mc_en),
    .mc_p1   (mc_p1),
    .mc_p2   (mc_p2),
    .mc_p3   (mc_p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiply cell: one registered stage, products update only when enabled.
  initial begin
    mc_p1 = '0;
    mc_p2 = '0;
    mc_p3 = '0;
  end
  always @(posedge clk) begin
    if (mc_en) begin
      mc_p1 <= {16'b0, mc_src1[15:0]} * {16'b0, mc_src2[15:0]};
      mc_p2 <= {16'b0, mc_src1[15:0]} * {16'b0, mc_src2[31:16]};
      mc_p3 <= {16'b0, mc_src1[31:16]} * {16'b0, mc_src2[15:0]};
    end
  end

  // Reference model: an accepted request yields the full 64-bit product word after a fixed latency.
  logic        m_busy, m_valid, m_hi;
  int          m_cnt, m_lat;
  logic [31:0] m_a, m_b, m_res, m_word;
  logic [63:0] m_prod;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_hi    <= 1'b0;
      m_cnt   <= 0;
      m_lat   <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_res   <= '0;
      m_word  <= '0;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        m_prod = 64'(bus.req_src1) * 64'(bus.req_src2);
        m_busy <= 1'b1;
        m_hi   <= bus.req_hi;
        m_cnt  <= 1;
        m_lat  <= bus.req_hi ? 5 : 3;
        m_a    <= bus.req_src1;
        m_b    <= bus.req_src2;
        m_word <= bus.req_hi ? m_prod[63:32] : m_prod[31:0];
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == m_lat) begin
        m_valid <= 1'b1;
        m_res   <= m_word;
      end
    end else if (bus.rsp_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic        e_en;
    logic [31:0] e_s1, e_s2;
    e_en = m_busy && !m_valid && (m_cnt == 1 || (m_hi && m_cnt == 3));
    e_s1 = m_a;
    e_s2 = m_b;
    if (m_busy && !m_valid && m_hi && m_cnt == 3) begin
      e_s1 = {16'b0, m_a[31:16]};
      e_s2 = {16'b0, m_b[31:16]};
    end
    chk("cyc_req_ready", 32'(bus.req_ready), 32'(!m_busy));
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    chk("cyc_rsp_result", bus.rsp_result, m_res);
    chk("cyc_mc_en", 32'(mc_en), 32'(e_en));
    chk("cyc_mc_src1", mc_src1, e_s1);
    chk("cyc_mc_src2", mc_src2, e_s2);
  end

  task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic hi);
    bus.req_valid = 1'b1;
    bus.req_src1  = a;
    bus.req_src2  = b;
    bus.req_hi    = hi;
  endtask

  // Returns one cycle after the accepting edge (cycle T+1).
  task automatic wait_accept(input string nm);
    int n = 0;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: req_ready never seen within 40 cycles", nm);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Starts in T+1; measures latency, mc_en pulses, and compares the result with a literal.
  task automatic wait_rsp(input logic [31:0] exp, input logic hi, input string nm);
    int t = 1;
    int en_n = 0;
    int first = -1;
    int last = -1;
    while (t <= 20) begin
      if (mc_en) begin
        en_n++;
        if (first < 0) first = t;
        last = t;
      end
      if (bus.rsp_valid) break;
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_latency"}, 32'(t), hi ? 32'd5 : 32'd3);
    chk({nm, "_result"}, bus.rsp_result, exp);
    chk({nm, "_en_cycles"}, 32'(en_n), hi ? 32'd2 : 32'd1);
    if (hi) chk({nm, "_en_gap"}, 32'(last - first), 32'd2);
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  // One full operation; early asks rsp_ready high from the start, which must be ignored until DONE.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic hi,
                    input logic [31:0] exp, input logic early, input string nm);
    start_req(a, b, hi);
    wait_accept(nm);
    if (early) bus.rsp_ready = 1'b1;
    wait_rsp(exp, hi, nm);
    finish_rsp();
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] ra, rb;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.req_hi    = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mc_en", 32'(mc_en), 32'd0);
    chk("rst_mc_src1", mc_src1, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    op(32'd7, 32'd6, 1'b0, 32'h0000002A, 1'b0, "lo_7x6");
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b1, "lo_ones");
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 1'b0, "hi_ones");
    op(32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b0, "lo_carry");
    op(32'h00010000, 32'h00010000, 1'b1, 32'h00000001, 1'b1, "hi_carry");
    op(32'h0000FFFF, 32'h00010001, 1'b0, 32'hFFFFFFFF, 1'b0, "lo_full");
    op(32'h0000FFFF, 32'h00010001, 1'b1, 32'h00000000, 1'b0, "hi_full");

    // Backpressure with a second request pending during DONE.
    start_req(32'd3, 32'd5, 1'b0);
    wait_accept("bp");
    wait_rsp(32'h0000000F, 1'b0, "bp");
    start_req(32'h00010000, 32'h00010000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_result", bus.rsp_result, 32'h0000000F);
      chk("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    finish_rsp();
    chk("bp_idle_after_handshake", 32'(bus.req_ready), 32'd1);
    wait_accept("bp_pending");
    wait_rsp(32'h00000001, 1'b1, "bp_pending");
    finish_rsp();

    // Reset asserted during PASS2.
    start_req(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_accept("rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_pass2_en", 32'(mc_en), 32'd1);
    chk("rst_mid_pass2_src1", mc_src1, 32'h0000FFFF);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_mc_en", 32'(mc_en), 32'd0);
    chk("rst_mid_mc_src1", mc_src1, 32'd0);
    chk("rst_mid_mc_src2", mc_src2, 32'd0);
    chk("rst_mid_result", bus.rsp_result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 1'b0, "after_rst");

    // A few pseudo-random operands checked against plain 64-bit multiplication.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      p  = 64'(ra) * 64'(rb);
      op(ra, rb, i[0], i[0] ? p[63:32] : p[31:0], i[1], "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aesproject_nios2_mul_seq.md
# aesproject_nios2_mul_seq

Multi-cycle sequencer that drives the CPU's three-product 16x16 multiply cell. It accepts 32x32 unsigned multiply requests over a valid/ready handshake and returns either the low or the high 32 bits of the 64-bit product. A low-word result needs one pass through the cell. A high-word result needs a second pass, which feeds the upper operand halves to obtain the hi*hi partial product. The block sits between a requester (custom-instruction or accelerator front end) and the mult cell instance, and is the only driver of the cell's operand and enable inputs.

## Interface
Parameters: none. Widths are fixed by the 16x16 cell.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge
- reset_n  in  1  reset, asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_src1  in  32  operand A, unsigned
- req_src2  in  32  operand B, unsigned
- req_hi  in  1  0 = return product[31:0]; 1 = return product[63:32]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_result  out  32  selected product word
- busy  out  1  high in every state except IDLE
- mc_src1  out  32  to cell E_src1
- mc_src2  out  32  to cell E_src2
- mc_en  out  1  to cell M_en (multiplier register enable)
- mc_p1  in  32  cell product A[15:0]*B[15:0]
- mc_p2  in  32  cell product A[15:0]*B[31:16]
- mc_p3  in  32  cell product A[31:16]*B[15:0]

## Operation
- State machine: IDLE, PASS1, CAP1, PASS2, CAP2, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch a_q=req_src1, b_q=req_src2, hi_q=req_hi, then go to PASS1.
- PASS1:
  - mc_src1=a_q, mc_src2=b_q, mc_en=1.
  - Go to CAP1.
- CAP1:
  - Products of PASS1 are valid on mc_p1..3.
  - Compute mid = mc_p2 + mc_p3 (33 bits).
  - Compute lo_acc = {32'b0,mc_p1} + (mid<<16) (64 bits); store it.
  - If hi_q=0: rsp_result := lo_acc[31:0], go to DONE. Otherwise go to PASS2.
- PASS2:
  - mc_src1={16'b0,a_q[31:16]}, mc_src2={16'b0,b_q[31:16]}, mc_en=1.
  - Go to CAP2.
- CAP2:
  - mc_p1 now holds A_hi*B_hi.
  - rsp_result := (lo_acc + {mc_p1,32'b0})[63:32].
  - Go to DONE.
- DONE:
  - rsp_valid=1.
  - On rsp_ready, go to IDLE. rsp_valid drops on the next cycle.
- mc_en=0 in every state except PASS1 and PASS2, so the cell holds its products.
- In states other than PASS2, mc_src1/mc_src2 show a_q/b_q.
- Arithmetic is modulo 2^64. There is no overflow flag.
- mc_p2 and mc_p3 from PASS2 are ignored.

## Timing
- Request accepted in cycle T, i.e. on the edge ending IDLE.
- Low word:
  - PASS1 = T+1, CAP1 = T+2.
  - rsp_valid first high at T+3.
  - Minimum latency 3 cycles.
- High word:
  - PASS1 = T+1, CAP1 = T+2, PASS2 = T+3, CAP2 = T+4.
  - rsp_valid first high at T+5.
  - Minimum latency 5 cycles.
- The cell is modelled with one registered stage: the product is visible on the cycle after mc_en is high.
- rsp_result and rsp_valid are registered. rsp_result is stable for as long as rsp_valid=1 and rsp_ready=0.
- Back-to-back operation: the response handshake completes at edge E, IDLE is entered at E, and the next request can be accepted in that IDLE cycle. Maximum throughput is 1 op per 4 cycles (low word) or per 6 cycles (high word).
- req_valid arriving while busy is not accepted and is not lost; the requester holds it until req_ready.
- Reset values: state=IDLE, req_ready=1 (combinational from state), rsp_valid=0, rsp_result=0, busy=0, mc_en=0, mc_src1=0, mc_src2=0, a_q=b_q=lo_acc=0.
- reset_n low in any state:
  - The operation is aborted immediately and no response is produced.
  - After release the block is in IDLE with all outputs at reset values.
- rsp_ready high outside DONE is ignored.

## Test plan
- Low word, 7*6: req_src1=7, req_src2=6, req_hi=0.
  - Required: rsp_result=0x0000002A, rsp_valid at T+3, mc_en high exactly 1 cycle.
- All-ones operands, 0xFFFFFFFF*0xFFFFFFFF:
  - Low word: rsp_result=0x00000001.
  - High word: rsp_result=0xFFFFFFFE at T+5, mc_en high for 2 non-adjacent cycles.
- Carry into the high half: 0x00010000*0x00010000 returns low=0x00000000 and high=0x00000001.
- Full low word, no high part: 0x0000FFFF*0x00010001 returns low=0xFFFFFFFF and high=0x00000000.
- Backpressure: hold rsp_ready=0 for 4 cycles in DONE.
  - rsp_result and rsp_valid stay stable; req_ready stays 0; a pending req_valid is accepted only after the handshake.
- Reset mid-operation: assert reset_n=0 during PASS2.
  - Outputs reach reset values asynchronously; no rsp_valid follows.
  - A new request after release completes with the correct result.
